fir_mac_seq: RTL and testbench

- Time-multiplexed FIR tap sequencer and accumulator for the approximate-filter datapath.
- Holds the sample delay line and the 11-bit coefficient bank, and feeds one (sample, coefficient) pair per cycle to an external combinational 32x11 truncated radix-4 multiplier.
- Accumulates the 32-bit products it returns and emits one filter output per accepted input sample.
- Sits directly upstream and downstream of the multiplier: it drives the multiplier's x/y and consumes its p.

---
 rtl/fir_mac_seq_if.sv | 37 +++
 rtl/fir_mac_seq.sv | 130 +++++++++++++
 tb/tb_fir_mac_seq.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fir_mac_seq_if.sv
// rtl/fir_mac_seq_if.sv - Bundle of sample, coefficient, multiplier and output signals for fir_mac_seq
//
// Signals:
//   in_valid/in_ready/in_sample     input sample handshake (32-bit signed)
//   coef_we/coef_addr/coef_data     coefficient bank write port (11-bit signed)
//   mul_x/mul_y/mul_p               external combinational multiplier operands/product
//   out_valid/out_ready/out_data    filter output handshake (ACC_W-bit signed)
// Modports:
//   slave  - the fir_mac_seq side
//   master - the side that feeds samples/coefficients and consumes outputs
interface fir_mac_seq_if #(
  parameter int ACC_W = 40,
  parameter int AW    = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_sample;
  logic             coef_we;
  logic [AW-1:0]    coef_addr;
  logic [10:0]      coef_data;
  logic [31:0]      mul_x;
  logic [10:0]      mul_y;
  logic [31:0]      mul_p;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;

  modport slave (
    input  in_valid, in_sample, coef_we, coef_addr, coef_data, mul_p, out_ready,
    output in_ready, mul_x, mul_y, out_valid, out_data
  );

  modport master (
    output in_valid, in_sample, coef_we, coef_addr, coef_data, mul_p, out_ready,
    input  in_ready, mul_x, mul_y, out_valid, out_data
  );
endinterface

// File: rtl/fir_mac_seq.sv
// rtl/fir_mac_seq.sv - Time-multiplexed FIR tap sequencer and accumulator
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - fir_mac_seq_if.slave: sample input, coefficient writes,
//          multiplier operands/product, filter output
// One (sample, coefficient) pair per cycle is presented to an external
// combinational multiplier; its product is accumulated over TAPS cycles and
// one output is produced per accepted input sample.
module fir_mac_seq #(
  parameter int  TAPS  = 8,
  parameter int  ACC_W = 40,
  localparam int AW    = $clog2(TAPS)
) (
  input  logic          clk,
  input  logic          rst,
  fir_mac_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t           state;
  state_t           state_next;

  logic [31:0]      d [TAPS];
  logic [10:0]      c [TAPS];
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] out_data_r;
  logic [AW-1:0]    idx;
  logic             out_valid_r;
  logic             accept;
  logic             last_tap;
  logic             coef_ok;

  // Product is signed; widen with sign so negative taps subtract.
  assign prod_ext = ACC_W'($signed(bus.mul_p));
  assign acc_sum  = acc + prod_ext;
  assign last_tap = (idx == AW'(TAPS - 1));
  assign coef_ok  = ({1'b0, bus.coef_addr} < (AW + 1)'(TAPS));

  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    bus.in_ready = 1'b0;
    bus.mul_x    = '0;
    bus.mul_y    = '0;
    accept       = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        accept       = bus.in_valid;
        if (bus.in_valid) begin
          state_next = MAC;
        end
      end
      MAC: begin
        bus.mul_x = d[idx];
        bus.mul_y = c[idx];
        if (last_tap) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_valid_r && bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        d[k] <= '0;
        c[k] <= '0;
      end
      acc         <= '0;
      idx         <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Coefficients only change between outputs, so a whole output
          // always sees one consistent bank.
          if (bus.coef_we && coef_ok) begin
            c[bus.coef_addr] <= bus.coef_data;
          end
          if (accept) begin
            d[0] <= bus.in_sample;
            for (int k = 1; k < TAPS; k++) begin
              d[k] <= d[k-1];
            end
            acc <= '0;
            idx <= '0;
          end
        end
        MAC: begin
          acc <= acc_sum;
          idx <= idx + 1'b1;
          if (last_tap) begin
            out_data_r  <= acc_sum;
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_seq.sv
// tb/tb_fir_mac_seq.sv - Self-checking bench for fir_mac_seq
module tb_fir_mac_seq;
  localparam int TAPS  = 8;
  localparam int ACC_W = 40;
  localparam int AW    = 3;

  typedef struct {
    logic [31:0]      sample;
    logic [ACC_W-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_mac_seq_if #(.ACC_W(ACC_W), .AW(AW)) bus ();

  fir_mac_seq #(.TAPS(TAPS), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Multiplier stand-in: low 32 bits of signed x * sign-extended y.
  logic signed [63:0] mprod;
  assign mprod = $signed({{32{bus.mul_x[31]}}, bus.mul_x}) *
                 $signed({{53{bus.mul_y[10]}}, bus.mul_y});
  assign bus.mul_p = mprod[31:0];

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0]      hist [TAPS];
  logic [10:0]      cm   [TAPS];
  logic [ACC_W-1:0] sb [$];
  vec_t             tab2 [TAPS];
  vec_t             tab3 [TAPS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [ACC_W-1:0] model_out();
    logic [ACC_W-1:0]   s;
    logic signed [63:0] p;
    s = '0;
    for (int k = 0; k < TAPS; k++) begin
      p = $signed({{32{hist[k][31]}}, hist[k]}) * $signed({{53{cm[k][10]}}, cm[k]});
      s = s + ACC_W'($signed(p[31:0]));
    end
    return s;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < TAPS; k++) begin
      hist[k] = '0;
      cm[k]   = '0;
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic write_coef(input logic [AW-1:0] a, input logic [10:0] v);
    bus.coef_we   = 1'b1;
    bus.coef_addr = a;
    bus.coef_data = v;
    @(posedge clk); #1;
    bus.coef_we = 1'b0;
    cm[a] = v;
  endtask

  task automatic send(input logic [31:0] s, input bit use_tab, input logic [ACC_W-1:0] tab_exp,
                      input bit cw_idle, input bit cw_mac, input logic [AW-1:0] ca,
                      input logic [10:0] cd);
    int cyc;
    bit seen;
    logic [ACC_W-1:0] e;
    cyc = 0;
    while (!bus.in_ready && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("in_ready_before_accept", 64'(bus.in_ready), 64'(1));
    bus.in_valid  = 1'b1;
    bus.in_sample = s;
    if (cw_idle) begin
      bus.coef_we   = 1'b1;
      bus.coef_addr = ca;
      bus.coef_data = cd;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.coef_we  = 1'b0;
    for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = s;
    if (cw_idle) cm[ca] = cd;
    sb.push_back(use_tab ? tab_exp : model_out());
    if (cw_mac) begin
      bus.coef_we   = 1'b1;
      bus.coef_addr = ca;
      bus.coef_data = cd;
    end
    seen = 1'b0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      bus.coef_we = 1'b0;
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("out_valid_timeout", 64'(0), 64'(1));
    else check("latency", 64'(cyc), 64'(TAPS));
    e = sb.pop_front();
    check("out_data", 64'(bus.out_data), 64'(e));
    if (bus.out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [ACC_W-1:0] hold;
    for (int i = 0; i < TAPS; i++) begin
      tab2[i] = '{sample: (i == 0) ? 32'd1 : 32'd0, exp: ACC_W'(i + 1)};
      tab3[i] = '{sample: 32'd5, exp: ACC_W'(0) - ACC_W'(5 * (i + 1))};
    end
    model_clear();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sample = '0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    bus.out_ready = 1'b1;

    // 1. reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_data", 64'(bus.out_data), 64'(0));
    check("rst_mul_x", 64'(bus.mul_x), 64'(0));
    check("rst_mul_y", 64'(bus.mul_y), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // 2. impulse response
    for (int k = 0; k < TAPS; k++) write_coef(AW'(k), 11'(k + 1));
    for (int i = 0; i < TAPS; i++) send(tab2[i].sample, 1'b1, tab2[i].exp, 1'b0, 1'b0, '0, '0);

    // 3. negative coefficients
    for (int k = 0; k < TAPS; k++) write_coef(AW'(k), 11'h7FF);
    for (int i = 0; i < TAPS; i++) send(tab3[i].sample, 1'b1, tab3[i].exp, 1'b0, 1'b0, '0, '0);
    check("neg_last_out", 64'(bus.out_data), 64'(40'hFFFFFFFFD8));

    // 4. backpressure
    bus.out_ready = 1'b0;
    send(32'hFFFF_FFF3, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    hold = bus.out_data;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_sample = 32'd999;
      @(posedge clk); #1;
      check("bp_out_valid", 64'(bus.out_valid), 64'(1));
      check("bp_out_stable", 64'(bus.out_data), 64'(hold));
      check("bp_in_ready", 64'(bus.in_ready), 64'(0));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", 64'(bus.in_ready), 64'(1));
    check("bp_release_out_valid", 64'(bus.out_valid), 64'(0));
    send(32'd3, 1'b0, '0, 1'b0, 1'b0, '0, '0);

    // 5. coefficient write lockout during MAC, then write in IDLE
    for (int k = 0; k < TAPS; k++) write_coef(AW'(k), 11'(k + 1));
    for (int i = 0; i < TAPS - 1; i++) send(32'd0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    send(32'd1, 1'b1, ACC_W'(1), 1'b0, 1'b1, AW'(0), 11'd100);
    for (int i = 0; i < TAPS - 1; i++) send(32'd0, 1'b1, ACC_W'(i + 2), 1'b0, 1'b0, '0, '0);
    send(32'd1, 1'b1, ACC_W'(100), 1'b1, 1'b0, AW'(0), 11'd100);

    // 6. asynchronous reset in the middle of MAC (idx == 3)
    bus.in_valid  = 1'b1;
    bus.in_sample = 32'd7;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    check("arst_in_ready", 64'(bus.in_ready), 64'(1));
    check("arst_out_valid", 64'(bus.out_valid), 64'(0));
    check("arst_out_data", 64'(bus.out_data), 64'(0));
    check("arst_mul_x", 64'(bus.mul_x), 64'(0));
    check("arst_mul_y", 64'(bus.mul_y), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    for (int k = 0; k < TAPS; k++) write_coef(AW'(k), 11'(k + 1));
    for (int i = 0; i < TAPS; i++) send(tab2[i].sample, 1'b1, tab2[i].exp, 1'b0, 1'b0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
